alu_seq_responder: RTL and testbench

- Sequential, handshaked ALU that serves operation requests (a, b, s) and returns a 6-bit result y, plus flags.
- Single-cycle ops complete directly; MUL and DIV run as W-cycle iterative shift-add / restoring-divide engines.
- Sits behind any requester (CPU stub, hardware sequencer, bench) through valid/ready on both request and response sides.

---
 rtl/alu_seq_responder.sv | 165 ++++++++++++++++
 tb/tb_alu_seq_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_responder.sv
// rtl/alu_seq_responder.sv - handshaked ALU with iterative shift-add multiply and restoring divide
// Single-cycle ops resolve at the accept edge; MUL/DIV take W further edges before HOLD.
module alu_seq_responder #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [3:0]     s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+1:0]   y,
  output logic [1:0]     flags
);

  localparam int YW = W + 2;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_out_valid;
  logic [YW-1:0]     r_y;
  logic [1:0]        r_flags;
  logic [CW-1:0]     r_cnt;
  logic [2*W-1:0]    r_mcand;
  logic [W-1:0]      r_mplier;
  logic [2*W-1:0]    r_prod;
  logic [W-1:0]      r_rem;
  logic [W-1:0]      r_quo;
  logic [W-1:0]      r_divisor;
  logic              r_dz;

  logic              w_accept;
  logic              w_last;
  logic [YW-1:0]     w_alu_y;
  logic [2*W-1:0]    w_prod_next;
  logic              w_sat;
  logic [W:0]        w_shift;
  logic              w_ge;
  logic [W-1:0]      w_sub;
  logic [W-1:0]      w_rem_next;
  logic [W-1:0]      w_quo_next;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == LAST);
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign flags     = r_flags;

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_sat       = |w_prod_next[2*W-1:YW];

  // Restoring divide: the remainder always stays below the divisor, so W bits suffice.
  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_sub      = w_shift[W-1:0] - r_divisor;
  assign w_rem_next = w_ge ? w_sub : w_shift[W-1:0];
  assign w_quo_next = {r_quo[W-2:0], w_ge};

  always_comb begin
    w_alu_y = '0;
    case (s)
      4'd0:    w_alu_y = {2'b00, a} + {2'b00, b};
      4'd1:    w_alu_y = {2'b00, a} - {2'b00, b};
      4'd4:    w_alu_y = {2'b00, a & b};
      4'd5:    w_alu_y = {2'b00, a | b};
      4'd6:    w_alu_y = {2'b00, a ^ b};
      4'd7:    w_alu_y = {2'b00, ~(a & b)};
      4'd8:    w_alu_y = {2'b00, ~(a | b)};
      4'd9:    w_alu_y = {2'b00, ~(a ^ b)};
      4'd10:   w_alu_y = {2'b00, ~a};
      4'd11:   w_alu_y = {1'b0, a, 1'b0};
      4'd12:   w_alu_y = {3'b000, a[W-1:1]};
      4'd13:   w_alu_y = {2'b00, a} + YW'(1);
      4'd14:   w_alu_y = {2'b00, a} - YW'(1);
      4'd15:   w_alu_y = {{(YW-2){1'b0}}, (a > b), (a == b)};
      default: w_alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      if (s == OP_MUL)      w_next = S_MUL;
      else if (s == OP_DIV) w_next = S_DIV;
      else                  w_next = S_HOLD;
    end else begin
      case (r_state)
        S_MUL, S_DIV: if (w_last) w_next = S_HOLD;
        S_HOLD:       if (out_ready) w_next = S_IDLE;
        default:      w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_flags     <= 2'b00;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_dz        <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (s == OP_MUL) begin
        r_mcand     <= {{W{1'b0}}, a};
        r_mplier    <= b;
        r_prod      <= '0;
        r_out_valid <= 1'b0;
      end else if (s == OP_DIV) begin
        r_rem       <= '0;
        r_quo       <= a;
        r_divisor   <= b;
        r_dz        <= (b == '0);
        r_out_valid <= 1'b0;
      end else begin
        r_y         <= w_alu_y;
        r_flags     <= 2'b00;
        r_out_valid <= 1'b1;
      end
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_y         <= w_sat ? '1 : w_prod_next[YW-1:0];
        r_flags     <= w_sat ? 2'b10 : 2'b00;
        r_out_valid <= 1'b1;
      end
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_y         <= r_dz ? '1 : {2'b00, w_quo_next};
        r_flags     <= r_dz ? 2'b01 : 2'b00;
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == S_HOLD) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_responder.sv
// tb/tb_alu_seq_responder.sv - directed and random checks of alu_seq_responder against an arithmetic model
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_seq_responder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   s = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W+1:0] y;
  logic [1:0]   flags;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_responder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result in the low W+2 bits, {ovf, dz} above them.
  function automatic logic [W+3:0] ref_model(input int ai, input int bi, input int si);
    int ymax;
    int amask;
    int r;
    int fl;
    ymax  = (1 << (W + 2)) - 1;
    amask = (1 << W) - 1;
    fl    = 0;
    case (si)
      0:  r = ai + bi;
      1:  r = (ai - bi) & ymax;
      2:  begin r = ai * bi; if (r > ymax) begin r = ymax; fl = 2; end end
      3:  begin if (bi == 0) begin r = ymax; fl = 1; end else r = ai / bi; end
      4:  r = ai & bi;
      5:  r = ai | bi;
      6:  r = ai ^ bi;
      7:  r = ~(ai & bi) & amask;
      8:  r = ~(ai | bi) & amask;
      9:  r = ~(ai ^ bi) & amask;
      10: r = ~ai & amask;
      11: r = (ai * 2) & ((1 << (W + 1)) - 1);
      12: r = ai / 2;
      13: r = ai + 1;
      14: r = (ai - 1) & ymax;
      default: r = ((ai > bi) ? 2 : 0) + ((ai == bi) ? 1 : 0);
    endcase
    return {fl[1:0], r[W+1:0]};
  endfunction

  task automatic run_op(input logic [3:0] s_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input int hold);
    logic [W+3:0] exp;
    int exp_lat;
    int lat;
    exp     = ref_model(int'(a_i), int'(b_i), int'(s_i));
    exp_lat = (s_i == 4'd2 || s_i == 4'd3) ? W + 1 : 1;
    check("in_ready_idle", in_ready, 1);
    a = a_i; b = b_i; s = s_i; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4 * W) begin
      check("in_ready_busy", in_ready, 0);
      step();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("y", y, exp[W+1:0]);
    check("flags", flags, exp[W+3:W+2]);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_y", y, exp[W+1:0]);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("in_ready_consume", in_ready, 1);
    step();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", flags, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);

    run_op(4'd0, 4'd8, 4'd2, 0);
    run_op(4'd1, 4'd2, 4'd12, 0);
    run_op(4'd14, 4'd0, 4'd0, 0);
    run_op(4'd2, 4'd12, 4'd2, 0);
    run_op(4'd2, 4'd15, 4'd15, 1);
    run_op(4'd3, 4'd13, 4'd2, 0);
    run_op(4'd3, 4'd12, 4'd0, 0);

    // CMP held under backpressure, then AND accepted on the consuming edge
    a = 4'd13; b = 4'd2; s = 4'd15; in_valid = 1'b1;
    step();
    check("cmp_valid", out_valid, 1);
    check("cmp_y", y, 2);
    a = 4'd12; b = 4'd10; s = 4'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_y", y, 2);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_y", y, 8);
    check("b2b_flags", flags, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b_drop", out_valid, 0);

    // Reset two cycles into a MUL
    a = 4'd12; b = 4'd2; s = 4'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_y", y, 0);
    check("mrst_flags", flags, 0);
    check("mrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("abort_no_result", out_valid, 0);
    end
    run_op(4'd0, 4'd1, 4'd1, 0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]   rs;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rs = 4'($urandom_range(15, 0));
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(rs, ra, rb, int'($urandom_range(2, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
